// File: rtl/fc_argmax_pkg.sv
// fc_argmax_pkg -- shared definitions for the fc_argmax classification head.
//   DATA_WIDTH / NUM_CLASS / IDX_W : default logit width, class count, index width
//   state_e                        : controller state encoding
//   signed_gt()                    : strict signed greater-than on sign-extended logits
package fc_argmax_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_CLASS  = 10;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Arguments are logits already sign-extended to int. Strict compare, so on
  // equal values the earlier (lower-index) holder keeps the win.
  function automatic logic signed_gt(input int a, input int b);
    return a > b;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp -- combinational compare-and-select step of the argmax scan.
// Ports:
//   cand_i / cand_idx_i : candidate logit and its class index
//   max_i  / idx_i      : current best logit and its index
//   max_o  / idx_o      : best after considering the candidate
//   take_o              : candidate is strictly greater (signed) than max_i
module argmax_cmp
  import fc_argmax_pkg::*;
#(
  parameter int DW = 8,
  parameter int IW = 4
) (
  input  logic [DW-1:0] cand_i,
  input  logic [IW-1:0] cand_idx_i,
  input  logic [DW-1:0] max_i,
  input  logic [IW-1:0] idx_i,
  output logic [DW-1:0] max_o,
  output logic [IW-1:0] idx_o,
  output logic          take_o
);

  assign take_o = signed_gt(int'($signed(cand_i)), int'($signed(max_i)));
  assign max_o  = take_o ? cand_i     : max_i;
  assign idx_o  = take_o ? cand_idx_i : idx_i;

endmodule

// File: rtl/fc_argmax.sv
// fc_argmax -- argmax classification head behind full_connect2.
// Captures NUM_CLASS signed logits, scans them one per clock and presents the
// winning index, its value and a one-hot vector on a valid/ready handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_logits  : logit bus (logit k at [k*DATA_WIDTH +: DATA_WIDTH])
//   in_ready             : high only while idle
//   out_valid, out_ready : result handshake
//   out_class, out_max   : winning index and logit (lowest index wins ties)
//   out_onehot           : bit out_class set
//   out_margin           : (FC_ARGMAX_MARGIN_EN only) max minus runner-up, unsigned
// Build option: define FC_ARGMAX_MARGIN_EN to add runner-up tracking and out_margin.
module fc_argmax #(
  parameter int DATA_WIDTH = fc_argmax_pkg::DATA_WIDTH,
  parameter int NUM_CLASS  = fc_argmax_pkg::NUM_CLASS,
  parameter int IDX_W      = fc_argmax_pkg::IDX_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [NUM_CLASS*DATA_WIDTH-1:0] in_logits,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                out_class,
  output logic [DATA_WIDTH-1:0]           out_max,
  output logic [NUM_CLASS-1:0]            out_onehot
`ifdef FC_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_WIDTH:0]             out_margin
`endif
);

  import fc_argmax_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_e                          state_q, state_d;
  logic [NUM_CLASS*DATA_WIDTH-1:0] logits_q, logits_d;
  logic [DATA_WIDTH-1:0]           max_q, max_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [IDX_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                out_class_q, out_class_d;
  logic [DATA_WIDTH-1:0]           out_max_q, out_max_d;
  logic [NUM_CLASS-1:0]            out_onehot_q, out_onehot_d;

  logic [DATA_WIDTH-1:0]           cand;
  logic [DATA_WIDTH-1:0]           cmp_max;
  logic [IDX_W-1:0]                cmp_idx;
  logic                            cmp_take;

  // The scan reads the captured copy, so the producer may change in_logits after t0.
  assign cand = logits_q[cnt_q * DATA_WIDTH +: DATA_WIDTH];

  argmax_cmp #(.DW(DATA_WIDTH), .IW(IDX_W)) u_cmp (
    .cand_i     (cand),
    .cand_idx_i (cnt_q),
    .max_i      (max_q),
    .idx_i      (idx_q),
    .max_o      (cmp_max),
    .idx_o      (cmp_idx),
    .take_o     (cmp_take)
  );

`ifdef FC_ARGMAX_MARGIN_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] second_q, second_d;
  logic [DATA_WIDTH-1:0] ru_max;
  logic [IDX_W-1:0]      ru_idx_unused;
  logic                  ru_take_unused;
  logic [DATA_WIDTH:0]   margin_q, margin_d;

  // Runner-up candidate path; only the value matters here.
  argmax_cmp #(.DW(DATA_WIDTH), .IW(IDX_W)) u_cmp_ru (
    .cand_i     (cand),
    .cand_idx_i (cnt_q),
    .max_i      (second_q),
    .idx_i      ('0),
    .max_o      (ru_max),
    .idx_o      (ru_idx_unused),
    .take_o     (ru_take_unused)
  );

  assign out_margin = margin_q;
`else
  logic take_unused;
  assign take_unused = cmp_take;
`endif

  // NOTE: every variable driven here gets a default first, so no path can hold
  // a stale value and infer a latch.
  always_comb begin
    state_d      = state_q;
    logits_d     = logits_q;
    max_d        = max_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    out_class_d  = out_class_q;
    out_max_d    = out_max_q;
    out_onehot_d = out_onehot_q;
`ifdef FC_ARGMAX_MARGIN_EN
    second_d     = second_q;
    margin_d     = margin_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          logits_d = in_logits;
          max_d    = in_logits[DATA_WIDTH-1:0];
          idx_d    = '0;
          cnt_d    = IDX_W'(1);
`ifdef FC_ARGMAX_MARGIN_EN
          // Starting at the most negative value makes the runner-up exact even
          // when every other logit equals it.
          second_d = MOST_NEG;
`endif
          state_d  = SCAN;
        end
      end
      SCAN: begin
        max_d = cmp_max;
        idx_d = cmp_idx;
`ifdef FC_ARGMAX_MARGIN_EN
        // A new maximum demotes the old one to runner-up.
        second_d = cmp_take ? max_q : ru_max;
`endif
        if (cnt_q == LAST_IDX) begin
          out_class_d  = cmp_idx;
          out_max_d    = cmp_max;
          out_onehot_d = NUM_CLASS'(1) << cmp_idx;
`ifdef FC_ARGMAX_MARGIN_EN
          // One extra bit holds the full signed span; max >= runner-up, so the
          // modular difference is the true unsigned margin.
          margin_d = {cmp_max[DATA_WIDTH-1], cmp_max} - {second_d[DATA_WIDTH-1], second_d};
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // NOTE: the logit store is reset as well, so the scan never reads an
      // unknown value even if the FSM is disturbed.
      logits_q     <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_class_q  <= '0;
      out_max_q    <= '0;
      out_onehot_q <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q     <= '0;
      margin_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      logits_q     <= logits_d;
      max_q        <= max_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      out_class_q  <= out_class_d;
      out_max_q    <= out_max_d;
      out_onehot_q <= out_onehot_d;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q     <= second_d;
      margin_q     <= margin_d;
`endif
    end
  end

  // Decoded straight from the state register so reset clears them without a clock.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_class  = out_class_q;
  assign out_max    = out_max_q;
  assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax -- scoreboard bench for fc_argmax.
// The driver pushes a reference result for every accepted inference; a monitor
// pops and compares each time out_valid rises. Define FC_ARGMAX_MARGIN_EN to
// also check out_margin.
module tb_fc_argmax;
  import fc_argmax_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int NC = NUM_CLASS;
  localparam int IW = IDX_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [NC*DW-1:0]  in_logits = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_class;
  logic [DW-1:0]     out_max;
  logic [NC-1:0]     out_onehot;
`ifdef FC_ARGMAX_MARGIN_EN
  logic [DW:0]       out_margin;
`endif

  fc_argmax dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_logits  (in_logits),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_max    (out_max),
    .out_onehot (out_onehot)
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    .out_margin (out_margin)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cls;
    int mx;
    int margin;
    int acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference: plain integer argmax over the logits, first occurrence wins;
  // runner-up is the largest logit at any other index.
  function automatic exp_t model(input logic [NC*DW-1:0] l, input int acc);
    int   v[NC];
    int   best;
    int   ru;
    bit   have_ru;
    exp_t e;
    for (int k = 0; k < NC; k++) v[k] = int'($signed(l[k*DW +: DW]));
    best = 0;
    for (int k = 1; k < NC; k++) if (v[k] > v[best]) best = k;
    ru = 0;
    have_ru = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (k != best && (!have_ru || v[k] > ru)) begin
        ru = v[k];
        have_ru = 1'b1;
      end
    end
    e.cls = best;
    e.mx = v[best];
    e.margin = v[best] - ru;
    e.acc_cyc = acc;
    return e;
  endfunction

  function automatic logic [NC-1:0] onehot_of(input int cls);
    logic [NC-1:0] oh;
    oh = '0;
    oh[cls] = 1'b1;
    return oh;
  endfunction

  function automatic logic [NC*DW-1:0] rand_logits();
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] const_logits(input logic [DW-1:0] v);
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  // Monitor: every rising out_valid is one result to check against the queue.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      check("result_expected", longint'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin : pop_blk
        automatic exp_t e = sb_q.pop_front();
        check("out_class", out_class, e.cls);
        check("out_max", longint'($signed(out_max)), e.mx);
        check("out_onehot", out_onehot, onehot_of(e.cls));
        check("latency", cyc - e.acc_cyc, NC - 1);
`ifdef FC_ARGMAX_MARGIN_EN
        check("out_margin", out_margin, e.margin);
`endif
      end
    end
    prev_valid <= out_valid;
  end

  // Call at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [NC*DW-1:0] l, input bit keep, input bit push,
                      output int acc);
    int n = 0;
    acc = -1;
    in_logits = l;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb_q.push_back(model(l, acc));
    in_logits = rand_logits();  // captured copy must be what gets scanned
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", out_valid, 1);
  endtask

  initial begin : main
    logic [NC*DW-1:0] l;
    logic [NC*DW-1:0] lb;
    exp_t e;
    int   acc;
    int   accs[3];
    int   n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_onehot", out_onehot, 0);
`ifdef FC_ARGMAX_MARGIN_EN
    check("rst_out_margin", out_margin, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Package compare function against plain arithmetic at the boundaries.
    check("gt_7f_80", signed_gt(127, -128), 1);
    check("gt_80_7f", signed_gt(-128, 127), 0);
    check("gt_equal", signed_gt(5, 5), 0);
    check("gt_m1_m2", signed_gt(-1, -2), 1);

    // Ascending logits; in_ready low and out_valid timing through the scan.
    out_ready = 1'b1;
    for (int k = 0; k < NC; k++) l[k*DW +: DW] = DW'(k);
    send(l, 1'b0, 1'b1, acc);
    for (int i = 0; i < NC; i++) begin
      check("busy_in_ready", in_ready, 0);
      check("busy_out_valid", out_valid, longint'(i == NC - 1));
      @(negedge clk);
    end
    check("idle_in_ready", in_ready, 1);

    // Most negative background with one -1; then an all-equal tie.
    l = const_logits(8'h80);
    l[3*DW +: DW] = 8'hFF;
    send(l, 1'b0, 1'b1, acc);
    send(const_logits(8'h05), 1'b0, 1'b1, acc);

    // Margin extremes: 0x7F over 0x80, and equal top two.
    l = const_logits(8'h80);
    l[6*DW +: DW] = 8'h7F;
    send(l, 1'b0, 1'b1, acc);
    l = const_logits(8'h10);
    l[2*DW +: DW] = 8'h40;
    l[7*DW +: DW] = 8'h40;
    send(l, 1'b0, 1'b1, acc);

    // Back-pressure: result held 20 cycles, stray in_valid ignored.
    l = rand_logits();
    send(l, 1'b0, 1'b1, acc);
    out_ready = 1'b0;
    wait_valid();
    e = model(l, 0);
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_class", out_class, e.cls);
      check("hold_max", longint'($signed(out_max)), e.mx);
      if (i == 5) begin
        in_logits = rand_logits();
        in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    lb = rand_logits();
    in_logits = lb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    send(lb, 1'b0, 1'b1, acc);

    // Asynchronous reset on the 4th scan cycle.
    send(rand_logits(), 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_scan_out_valid", out_valid, 0);
    check("rst_scan_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(rand_logits(), 1'b0, 1'b1, acc);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_in_ready", in_ready, 1);
    check("rst_done_out_max", out_max, 0);
    check("rst_done_out_onehot", out_onehot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Fresh inference after reset, then random traffic with idle gaps.
    send(rand_logits(), 1'b0, 1'b1, acc);
    for (int j = 0; j < 12; j++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rand_logits(), 1'b0, 1'b1, acc);
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int j = 0; j < 3; j++) send(rand_logits(), 1'b1, 1'b1, accs[j]);
    in_valid = 1'b0;
    check("b2b_period_1", accs[1] - accs[0], NC + 1);
    check("b2b_period_2", accs[2] - accs[1], NC + 1);

    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
